zoom_controller: RTL and testbench

Sequencing controller for the nearest-neighbour interpolation engine in the ALU path. It accepts zoom commands from the host/HPS side, validates the scale factor, and drives the engine's active-low restart and `fator` inputs. It waits for the engine's `done`, then swaps the double-buffered frame RAM so the VGA reader always sees a complete frame. It sits between the command register interface and the interpolation engine/RAM bank mux.

---
 rtl/zoom_pkg.sv | 22 ++
 rtl/zoom_watchdog.sv | 21 ++
 rtl/zoom_controller.sv | 104 ++++++++++
 tb/tb_zoom_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/zoom_pkg.sv
// Shared constants, FSM encodings and the factor legality check for the zoom controller.
package zoom_pkg;
  localparam int FATOR_W       = 3;
  localparam int LARGURA_DEF   = 160;
  localparam int ALTURA_DEF    = 120;
  localparam int MAX_FATOR_DEF = 5;
  localparam int RAM_WORDS     = 1 << 19;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_SWAP  = 2'd3;

  // A factor is legal when it is non-zero, within the configured maximum
  // and the zoomed frame still fits one RAM bank.
  function automatic logic fator_ok(input logic [FATOR_W-1:0] f, input int max_f,
                                    input int w, input int h);
    return (f != '0) && (int'(f) <= max_f) &&
           (w * h * int'(f) * int'(f) <= RAM_WORDS);
  endfunction
endpackage

// File: rtl/zoom_watchdog.sv
// RUN-state watchdog: cleared on load, counts while enabled, flags expiry on the LIMIT-th cycle.
module zoom_watchdog #(
  parameter int LIMIT = 1048576,
  parameter int W     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign expire = en && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/zoom_controller.sv
// Sequencer for the nearest-neighbour zoom engine with double-buffered frame RAM.
// Optional RUN watchdog enabled by defining ZOOM_TIMEOUT_EN.
module zoom_controller
  import zoom_pkg::*;
#(
  parameter int LARGURA        = LARGURA_DEF,
  parameter int ALTURA         = ALTURA_DEF,
  parameter int MAX_FATOR      = MAX_FATOR_DEF,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [FATOR_W-1:0] cmd_fator,
  output logic               cmd_ready,
  input  logic               cmd_abort,
  output logic               eng_rst_n,
  output logic [FATOR_W-1:0] eng_fator,
  input  logic               eng_done,
  output logic               wr_bank,
  output logic               disp_bank,
  output logic [FATOR_W-1:0] active_fator,
  output logic               busy,
  output logic               err,
  output logic               frame_done,
  output logic [7:0]         frame_count
);
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_t           state, state_nxt;
  logic [CLR_W-1:0] clr_cnt;
  logic             fator_legal;
  logic             timeout;

  assign fator_legal = fator_ok(cmd_fator, MAX_FATOR, LARGURA, ALTURA);

`ifdef ZOOM_TIMEOUT_EN
  zoom_watchdog #(.LIMIT(TIMEOUT_CYCLES), .W(20)) u_wd (
    .clk    (clk),
    .reset  (reset),
    .load   (state == ST_CLEAR && state_nxt == ST_RUN),
    .en     (state == ST_RUN),
    .expire (timeout)
  );
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Abort beats done, done beats watchdog expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid && fator_legal) state_nxt = ST_CLEAR;
      ST_CLEAR: if (cmd_abort) state_nxt = ST_IDLE;
                else if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nxt = ST_RUN;
      ST_RUN:   if (cmd_abort) state_nxt = ST_IDLE;
                else if (eng_done) state_nxt = ST_SWAP;
                else if (timeout) state_nxt = ST_IDLE;
      ST_SWAP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      clr_cnt      <= '0;
      eng_rst_n    <= 1'b0;
      eng_fator    <= FATOR_W'(1);
      wr_bank      <= 1'b0;
      active_fator <= FATOR_W'(1);
      err          <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      eng_rst_n  <= (state_nxt == ST_RUN);
      frame_done <= (state_nxt == ST_SWAP);
      if (state == ST_IDLE && cmd_valid) begin
        if (fator_legal) begin
          eng_fator <= cmd_fator;
          err       <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (state == ST_RUN && state_nxt == ST_IDLE && !cmd_abort && timeout)
        err <= 1'b1;
      // The swap is committed on entry to SWAP so bank, factor and count move together.
      if (state == ST_RUN && state_nxt == ST_SWAP) begin
        wr_bank      <= ~wr_bank;
        active_fator <= eng_fator;
        frame_count  <= frame_count + 1'b1;
      end
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign disp_bank = ~wr_bank;
endmodule

// File: tb/tb_zoom_controller.sv
// Directed bench for zoom_controller; timeout scenario runs when ZOOM_TIMEOUT_EN is defined.
module tb_zoom_controller;
  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_abort, eng_done;
  logic [2:0] cmd_fator;
  logic       cmd_ready, eng_rst_n, wr_bank, disp_bank, busy, err, frame_done;
  logic [2:0] eng_fator, active_fator;
  logic [7:0] frame_count;
  int n_checks = 0;
  int n_fail   = 0;

  zoom_controller #(.CLR_CYCLES(2), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_fator(cmd_fator),
    .cmd_ready(cmd_ready), .cmd_abort(cmd_abort), .eng_rst_n(eng_rst_n),
    .eng_fator(eng_fator), .eng_done(eng_done), .wr_bank(wr_bank),
    .disp_bank(disp_bank), .active_fator(active_fator), .busy(busy), .err(err),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " eng_rst_n"}, 32'(eng_rst_n), 0);
    chk({tag, " eng_fator"}, 32'(eng_fator), 1);
    chk({tag, " wr_bank"}, 32'(wr_bank), 0);
    chk({tag, " disp_bank"}, 32'(disp_bank), 1);
    chk({tag, " active_fator"}, 32'(active_fator), 1);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " frame_done"}, 32'(frame_done), 0);
    chk({tag, " frame_count"}, 32'(frame_count), 0);
  endtask

  initial begin
    int low_cnt;
    reset = 1'b1; cmd_valid = 1'b0; cmd_fator = '0; cmd_abort = 1'b0; eng_done = 1'b0;
    step(); step();
    chk_reset_vals("reset");
    reset = 1'b0;
    step();

    // Frame with factor 2, engine done 100 cycles after restart release
    cmd_valid = 1'b1; cmd_fator = 3'd2;
    step();
    cmd_valid = 1'b0;
    chk("accept busy", 32'(busy), 1);
    chk("accept eng_fator", 32'(eng_fator), 2);
    low_cnt = 0;
    for (int i = 0; i < 10 && eng_rst_n !== 1'b1; i++) begin
      low_cnt++;
      step();
    end
    chk("clear low cycles", 32'(low_cnt), 2);
    chk("run eng_rst_n", 32'(eng_rst_n), 1);
    repeat (99) step();
    chk("run no early swap", 32'(frame_done), 0);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("f1 frame_done", 32'(frame_done), 1);
    chk("f1 wr_bank", 32'(wr_bank), 1);
    chk("f1 disp_bank", 32'(disp_bank), 0);
    chk("f1 active_fator", 32'(active_fator), 2);
    chk("f1 frame_count", 32'(frame_count), 1);
    step();
    chk("f1 pulse ends", 32'(frame_done), 0);
    chk("f1 idle ready", 32'(cmd_ready), 1);
    chk("f1 idle rst_n", 32'(eng_rst_n), 0);

    // Illegal factors 0 and 6, then legal 3 clears err
    cmd_valid = 1'b1; cmd_fator = 3'd0;
    step();
    chk("fator0 err", 32'(err), 1);
    chk("fator0 busy", 32'(busy), 0);
    chk("fator0 eng_fator", 32'(eng_fator), 2);
    cmd_fator = 3'd6;
    step();
    chk("fator6 err", 32'(err), 1);
    chk("fator6 busy", 32'(busy), 0);
    chk("fator6 rst_n", 32'(eng_rst_n), 0);
    // eng_done stuck high across the whole run
    cmd_fator = 3'd3; eng_done = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("fator3 err cleared", 32'(err), 0);
    chk("fator3 busy", 32'(busy), 1);
    chk("stuck clear1 no swap", 32'(frame_done), 0);
    step();
    chk("stuck clear2 no swap", 32'(frame_done), 0);
    chk("stuck clear2 wr_bank", 32'(wr_bank), 1);
    step();
    chk("stuck run rst_n", 32'(eng_rst_n), 1);
    chk("stuck run no swap", 32'(frame_done), 0);
    step();
    eng_done = 1'b0;
    chk("stuck swap frame_done", 32'(frame_done), 1);
    chk("stuck swap wr_bank", 32'(wr_bank), 0);
    chk("stuck swap active", 32'(active_fator), 3);
    chk("stuck swap count", 32'(frame_count), 2);
    step();

    // Abort together with done in RUN
    cmd_valid = 1'b1; cmd_fator = 3'd4;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("abort pre run", 32'(eng_rst_n), 1);
    cmd_abort = 1'b1; eng_done = 1'b1;
    step();
    cmd_abort = 1'b0; eng_done = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort rst_n", 32'(eng_rst_n), 0);
    chk("abort wr_bank", 32'(wr_bank), 0);
    chk("abort count", 32'(frame_count), 2);
    chk("abort frame_done", 32'(frame_done), 0);
    chk("abort active", 32'(active_fator), 3);

    // Abort during CLEAR
    cmd_valid = 1'b1; cmd_fator = 3'd5;
    step();
    cmd_valid = 1'b0; cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("clear abort busy", 32'(busy), 0);
    chk("clear abort rst_n", 32'(eng_rst_n), 0);
    step();
    chk("clear abort stays idle", 32'(busy), 0);

`ifdef ZOOM_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_fator = 3'd1;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("wd run", 32'(eng_rst_n), 1);
    repeat (49) step();
    chk("wd before expiry busy", 32'(busy), 1);
    chk("wd before expiry err", 32'(err), 0);
    step();
    chk("wd expiry err", 32'(err), 1);
    chk("wd expiry busy", 32'(busy), 0);
    chk("wd expiry rst_n", 32'(eng_rst_n), 0);
    chk("wd no swap", 32'(frame_count), 2);
`endif

    // Reset asserted mid-RUN
    cmd_valid = 1'b1; cmd_fator = 3'd5;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("midrun rst_n", 32'(eng_rst_n), 1);
    chk("midrun eng_fator", 32'(eng_fator), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("midrun reset");
    step();

    // 256 frames: counter and bank wrap
    for (int i = 0; i < 256; i++) begin
      cmd_valid = 1'b1; cmd_fator = 3'd2; eng_done = 1'b1;
      step();
      cmd_valid = 1'b0;
      repeat (4) step();
      if (i == 254) chk("wrap count 255", 32'(frame_count), 255);
    end
    eng_done = 1'b0;
    chk("wrap count", 32'(frame_count), 0);
    chk("wrap wr_bank", 32'(wr_bank), 0);
    chk("wrap disp_bank", 32'(disp_bank), 1);
    chk("wrap active", 32'(active_fator), 2);
    chk("wrap idle", 32'(cmd_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
